// File: rtl/clk_gen_meter.sv
// Purpose: counts rising edges of an asynchronous clock over a programmable window of clk_i cycles.
// Latency: the result is valid window_i cycles after start is accepted; the observed window trails by SYNC_STAGES+1 cycles.
// Backpressure: the result holds in DONE until yumi_i; start_v_i is accepted only while ready_o is high.
module clk_gen_meter #(
    parameter int unsigned WINDOW_W    = 16,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                meas_clk_i,
    input  logic                start_v_i,
    input  logic [WINDOW_W-1:0] window_i,
    output logic                ready_o,
    output logic                v_o,
    output logic [CNT_W-1:0]    count_o,
    output logic                overflow_o,
    input  logic                yumi_i
);

    localparam int unsigned WARM_W = $clog2(SYNC_STAGES + 1) + 1;

    typedef enum logic [1:0] {
        WARM,
        IDLE,
        MEASURE,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise;
    logic [WARM_W-1:0]      warm_cnt_q;
    logic [WINDOW_W-1:0]    win_cnt_q;
    logic [CNT_W-1:0]       count_q;
    logic                   ovf_q;

    assign rise       = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= WARM;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        v_o     = 1'b0;
        case (state_q)
            WARM: begin
                if (warm_cnt_q == WARM_W'(SYNC_STAGES)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                ready_o = 1'b1;
                if (start_v_i) begin
                    if (window_i == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = MEASURE;
                    end
                end
            end
            MEASURE: begin
                if (win_cnt_q == WINDOW_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = WARM;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q     <= '0;
            prev_q     <= 1'b0;
            warm_cnt_q <= '0;
            win_cnt_q  <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], meas_clk_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            case (state_q)
                // Rises seen while warming up come from priming the synchronizer and are dropped.
                WARM: warm_cnt_q <= warm_cnt_q + WARM_W'(1);
                IDLE: begin
                    if (start_v_i) begin
                        win_cnt_q <= window_i;
                        count_q   <= '0;
                        ovf_q     <= 1'b0;
                    end
                end
                MEASURE: begin
                    win_cnt_q <= win_cnt_q - WINDOW_W'(1);
                    if (rise) begin
                        if (count_q == {CNT_W{1'b1}}) begin
                            ovf_q <= 1'b1;
                        end else begin
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_gen_meter.sv
// Directed bench for clk_gen_meter: a 16-bit and a 4-bit counter instance share all inputs.
// The measured clock is generated from clk_i at constant-1, clk_i/2 or clk_i/4.
module tb_clk_gen_meter;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        meas_clk_i;
    logic        start_v_i;
    logic [15:0] window_i;
    logic        yumi_i;

    logic        ready_w, v_w, ovf_w;
    logic [15:0] count_w;
    logic        ready_n, v_n, ovf_n;
    logic [3:0]  count_n;

    int n_pass  = 0;
    int n_total = 0;
    int mode    = 0;
    logic [1:0] ph;

    clk_gen_meter #(.WINDOW_W(16), .CNT_W(16), .SYNC_STAGES(2)) u_wide (
        .clk_i(clk_i), .reset_i(reset_i), .meas_clk_i(meas_clk_i),
        .start_v_i(start_v_i), .window_i(window_i), .ready_o(ready_w),
        .v_o(v_w), .count_o(count_w), .overflow_o(ovf_w), .yumi_i(yumi_i)
    );

    clk_gen_meter #(.WINDOW_W(16), .CNT_W(4), .SYNC_STAGES(2)) u_narrow (
        .clk_i(clk_i), .reset_i(reset_i), .meas_clk_i(meas_clk_i),
        .start_v_i(start_v_i), .window_i(window_i), .ready_o(ready_n),
        .v_o(v_n), .count_o(count_n), .overflow_o(ovf_n), .yumi_i(yumi_i)
    );

    initial forever #5 clk_i = ~clk_i;

    initial begin
        ph         = 2'd0;
        meas_clk_i = 1'b1;
        forever begin
            @(negedge clk_i);
            ph = ph + 2'd1;
            case (mode)
                2:       meas_clk_i = ph[0];
                4:       meas_clk_i = ph[1];
                default: meas_clk_i = 1'b1;
            endcase
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Start a run and check the exact cycle at which the result appears.
    task automatic run_meas(input int w);
        start_v_i = 1'b1;
        window_i  = 16'(w);
        tick(1);
        start_v_i = 1'b0;
        if (w > 0) begin
            tick(w - 1);
            chk("v_before_window_end", {31'd0, v_w}, 32'd0);
            tick(1);
        end
        chk("v_at_window_end", {31'd0, v_w}, 32'd1);
    endtask

    task automatic consume();
        yumi_i = 1'b1;
        tick(1);
        yumi_i = 1'b0;
        chk("v_after_yumi", {31'd0, v_w}, 32'd0);
        chk("ready_after_yumi", {31'd0, ready_w}, 32'd1);
    endtask

    task automatic set_mode(input int m);
        mode = m;
        tick(8);
    endtask

    initial begin
        reset_i   = 1'b1;
        start_v_i = 1'b0;
        window_i  = 16'd0;
        yumi_i    = 1'b0;
        tick(5);

        // Reset state and warm-up length
        chk("rst_ready", {31'd0, ready_w}, 32'd0);
        chk("rst_v", {31'd0, v_w}, 32'd0);
        chk("rst_count", {16'd0, count_w}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_w}, 32'd0);
        reset_i = 1'b0;
        chk("warm_ready_c1", {31'd0, ready_w}, 32'd0);
        tick(1);
        chk("warm_ready_c2", {31'd0, ready_w}, 32'd0);
        tick(1);
        chk("warm_ready_c3", {31'd0, ready_w}, 32'd0);
        tick(1);
        chk("warm_ready_done", {31'd0, ready_w}, 32'd1);

        // Constant-high input: priming rise must not be counted
        run_meas(10);
        chk("const_count", {16'd0, count_w}, 32'd0);
        chk("const_ovf", {31'd0, ovf_w}, 32'd0);
        consume();

        // clk_i/4 over 100 cycles, result holds without yumi
        set_mode(4);
        run_meas(100);
        chk("div4_count", {16'd0, count_w}, 32'd25);
        chk("div4_ovf", {31'd0, ovf_w}, 32'd0);
        chk("div4_narrow_ovf", {31'd0, ovf_n}, 32'd1);
        tick(20);
        chk("hold_v", {31'd0, v_w}, 32'd1);
        chk("hold_count", {16'd0, count_w}, 32'd25);
        consume();

        // Zero-length window
        run_meas(0);
        chk("win0_count", {16'd0, count_w}, 32'd0);
        chk("win0_ovf", {31'd0, ovf_w}, 32'd0);
        consume();

        // Saturation on the 4-bit instance, then overflow cleared by the next run
        set_mode(2);
        run_meas(40);
        chk("sat_narrow_count", {28'd0, count_n}, 32'd15);
        chk("sat_narrow_ovf", {31'd0, ovf_n}, 32'd1);
        chk("sat_wide_count", {16'd0, count_w}, 32'd20);
        consume();
        set_mode(4);
        run_meas(20);
        chk("post_sat_count", {28'd0, count_n}, 32'd5);
        chk("post_sat_ovf", {31'd0, ovf_n}, 32'd0);
        consume();

        // start_v_i during MEASURE is ignored
        set_mode(2);
        start_v_i = 1'b1;
        window_i  = 16'd50;
        tick(1);
        start_v_i = 1'b0;
        tick(5);
        start_v_i = 1'b1;
        window_i  = 16'd3;
        tick(1);
        start_v_i = 1'b0;
        chk("measure_ready", {31'd0, ready_w}, 32'd0);
        tick(43);
        chk("ign_v_before", {31'd0, v_w}, 32'd0);
        tick(1);
        chk("ign_v", {31'd0, v_w}, 32'd1);
        chk("ign_count", {16'd0, count_w}, 32'd25);
        consume();

        // yumi_i in IDLE has no effect and the last result is kept
        yumi_i = 1'b1;
        tick(1);
        yumi_i = 1'b0;
        chk("idle_yumi_ready", {31'd0, ready_w}, 32'd1);
        chk("idle_yumi_v", {31'd0, v_w}, 32'd0);
        chk("idle_keep_count", {16'd0, count_w}, 32'd25);

        // Reset in the middle of a measurement
        start_v_i = 1'b1;
        window_i  = 16'd50;
        tick(1);
        start_v_i = 1'b0;
        tick(10);
        reset_i = 1'b1;
        tick(1);
        reset_i = 1'b0;
        chk("mid_rst_v", {31'd0, v_w}, 32'd0);
        chk("mid_rst_count", {16'd0, count_w}, 32'd0);
        chk("mid_rst_ready_c1", {31'd0, ready_w}, 32'd0);
        tick(1);
        chk("mid_rst_ready_c2", {31'd0, ready_w}, 32'd0);
        tick(1);
        chk("mid_rst_ready_c3", {31'd0, ready_w}, 32'd0);
        tick(1);
        chk("mid_rst_ready_done", {31'd0, ready_w}, 32'd1);

        // yumi and start together in DONE: start is not taken until IDLE
        set_mode(4);
        run_meas(8);
        chk("b2b_first_count", {16'd0, count_w}, 32'd2);
        yumi_i    = 1'b1;
        start_v_i = 1'b1;
        window_i  = 16'd8;
        tick(1);
        yumi_i = 1'b0;
        chk("b2b_not_taken_ready", {31'd0, ready_w}, 32'd1);
        chk("b2b_not_taken_v", {31'd0, v_w}, 32'd0);
        tick(1);
        start_v_i = 1'b0;
        chk("b2b_taken_ready", {31'd0, ready_w}, 32'd0);
        tick(7);
        chk("b2b_v_before", {31'd0, v_w}, 32'd0);
        tick(1);
        chk("b2b_v", {31'd0, v_w}, 32'd1);
        chk("b2b_count", {16'd0, count_w}, 32'd2);
        consume();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_gen_meter.md
Name: clk_gen_meter

Overview:
- Measures the frequency of the clock produced by the tunable clock generator (clk_gen / clk_gen_top clk_o).
- Samples that clock as an asynchronous data input in the reference clk_i domain and counts its rising edges over a programmable window of clk_i cycles.
- Returns the count through a valid/yumi handshake.
- Lets the test harness sweep select_i and read back the generated frequency without an external counter.

Parameters:
- WINDOW_W, 16: width of window length input, in clk_i cycles.
- CNT_W, 16: width of edge count result.
- SYNC_STAGES, 2: synchronizer flops on meas_clk_i (minimum 2).

Ports:
- clk_i  input  1  reference clock; all state on its rising edge.
- reset_i  input  1  synchronous, active-high reset.
- meas_clk_i  input  1  clock under test (clk_gen clk_o), asynchronous to clk_i.
- start_v_i  input  1  start request; accepted only when ready_o=1.
- window_i  input  WINDOW_W  measurement length in clk_i cycles; captured on start accept.
- ready_o  output  1  block idle and able to accept start.
- v_o  output  1  result valid.
- count_o  output  CNT_W  rising edges counted in window; stable while v_o=1.
- overflow_o  output  1  count saturated and at least one further edge was seen.
- yumi_i  input  1  consumer takes result; legal only while v_o=1.

Behaviour:
- One clock, clk_i. reset_i is synchronous and active-high.
- Front end: meas_clk_i passes through a SYNC_STAGES flop chain, then one edge flop prev.
  - rise = sync_out & ~prev.
  - All of these flops reset to 0.
- FSM states: WARM, IDLE, MEASURE, DONE. Reset forces WARM from any state, including mid-MEASURE or DONE.
- Reset values:
  - ready_o=0, v_o=0, count_o=0, overflow_o=0.
  - Window counter = 0; warm counter = 0.
- WARM:
  - Lasts exactly SYNC_STAGES+1 cycles after reset_i deasserts, then goes to IDLE.
  - Any synchronizer-priming rise is discarded here.
- IDLE:
  - ready_o=1.
  - On start_v_i=1: capture window_i.
    - window_i=0: go to DONE with count=0 and overflow=0; v_o rises the next cycle.
    - Otherwise: load the window counter with window_i, clear count and overflow, go to MEASURE.
- MEASURE:
  - ready_o=0; start_v_i is ignored (no queuing).
  - Each cycle, if rise=1:
    - count < 2^CNT_W-1: count increments.
    - Otherwise: count holds and overflow_o sets (sticky until next start).
  - Window counter decrements each cycle. MEASURE lasts exactly window_i cycles, so exactly window_i rise samples are evaluated.
  - Then go to DONE.
- DONE:
  - v_o=1; count_o and overflow_o hold.
  - yumi_i=1: go to IDLE next cycle, v_o drops.
  - Start is accepted no earlier than the cycle after yumi_i.
- Handshake rules:
  - yumi_i while v_o=0 is ignored.
  - count_o and overflow_o keep their last value in IDLE until the next start.
- Input limits and accuracy:
  - meas_clk_i high and low phases must each be ≥1 clk_i period for a correct count.
  - Asynchronous accuracy is ±1 edge.
  - Synchronizer latency shifts the observed window by SYNC_STAGES+1 cycles with no change in length.
- Arithmetic:
  - Window counter is WINDOW_W bits, unsigned.
  - Count is CNT_W bits, saturating and never wraps.

Test Plan:
1. Reset release, SYNC_STAGES=2, meas_clk_i held 1 through reset -> ready_o=0 for exactly 3 cycles then 1. Start with window=10 and meas constant 1 -> count_o=0, overflow_o=0.
2. meas_clk_i driven from the bench at clk_i/4 (2 high, 2 low), window=100 -> v_o=1 with count_o=25, overflow_o=0. v_o and count_o hold 20 cycles with yumi_i=0; yumi_i=1 -> v_o=0 and ready_o=1 next cycle.
3. window=0 start -> v_o=1 one cycle after accept, count_o=0, overflow_o=0.
4. CNT_W=4, meas at clk_i/2, window=40 (20 edges) -> count_o=15, overflow_o=1. Next run at clk_i/4 with window=20 -> count_o=5, overflow_o=0.
5. start_v_i pulsed during MEASURE with window_i=3 -> ignored; original window=50 result returned. yumi_i pulsed in IDLE -> no effect. reset_i asserted mid-MEASURE -> v_o=0, ready_o=0 for 3 cycles after release, count_o=0.
6. Back-to-back: yumi_i and start_v_i asserted in the same DONE cycle -> start not accepted. start in the following IDLE cycle with window=8, meas clk_i/4 -> count_o=2.
